// File: rtl/bnn_window_streamer.sv
// Input front-end for the BNN accelerator: binarises a packed pixel stream into
// KSIZE x KSIZE windows through a line buffer and holds the grouped weight set.
module bnn_window_streamer #(
  parameter int unsigned IMG_W        = 20,
  parameter int unsigned IMG_H        = 20,
  parameter int unsigned KSIZE        = 4,
  parameter int unsigned STRIDE       = 1,
  parameter int unsigned PIX_PER_BEAT = 2,
  parameter int unsigned THRESH       = 127,
  parameter int unsigned WGROUPS      = 11,
  parameter int unsigned WPER_GROUP   = 6
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    mode,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [8*PIX_PER_BEAT-1:0]               data_in,
  input  logic                                    weight_req,
  output logic [WPER_GROUP*8*PIX_PER_BEAT-1:0]    weight_out,
  output logic                                    weights_loaded,
  output logic                                    win_valid,
  input  logic                                    win_ready,
  output logic [KSIZE*KSIZE-1:0]                  win_data,
  output logic [$clog2(IMG_H)-1:0]                win_row,
  output logic [$clog2(IMG_W)-1:0]                win_col,
  output logic                                    frame_done
);

  localparam int unsigned DW       = 8 * PIX_PER_BEAT;
  localparam int unsigned RW       = $clog2(IMG_H);
  localparam int unsigned CW       = $clog2(IMG_W);
  localparam int unsigned HW       = $clog2(PIX_PER_BEAT + 1);
  localparam int unsigned LB_LEN   = (KSIZE - 1) * IMG_W + KSIZE;
  localparam int unsigned WIN_BITS = KSIZE * KSIZE;
  localparam int unsigned GW       = (WGROUPS > 1) ? $clog2(WGROUPS) : 1;
  localparam int unsigned SW       = (WPER_GROUP > 1) ? $clog2(WPER_GROUP) : 1;

  logic [DW-1:0]       hold;
  logic [HW-1:0]       hcnt;
  logic [LB_LEN-2:0]   lb;
  logic [LB_LEN-1:0]   lb_next;
  logic [RW-1:0]       r;
  logic [CW-1:0]       c;
  logic                shift_en;
  logic                pix_acc;
  logic                wt_acc;
  logic                pix_bit;
  logic                row_ok;
  logic                col_ok;
  logic                last_pix;
  logic                win_load;
  logic [WIN_BITS-1:0] win_next;

  logic [DW-1:0]       wmem [WGROUPS][WPER_GROUP];
  logic [GW-1:0]       gptr;
  logic [GW-1:0]       wgrp;
  logic [SW-1:0]       wslot;

  // Handshake and shift control; a stalled window freezes the pixel pipeline.
  always_comb begin
    shift_en = (hcnt != '0) && !(win_valid && !win_ready);
    in_ready = mode ? 1'b1 : ((hcnt == '0) || ((hcnt == HW'(1)) && shift_en));
    pix_acc  = in_valid && in_ready && !mode;
    wt_acc   = in_valid && mode;
  end

  // Binarise the next byte and form the window taps from the post-shift buffer.
  always_comb begin
    pix_bit  = hold[7:0] > 8'(THRESH);
    lb_next  = {lb, pix_bit};
    row_ok   = (32'(r) >= KSIZE - 1) && (((32'(r) - (KSIZE - 1)) % STRIDE) == 32'd0);
    col_ok   = (32'(c) >= KSIZE - 1) && (((32'(c) - (KSIZE - 1)) % STRIDE) == 32'd0);
    last_pix = (r == RW'(IMG_H - 1)) && (c == CW'(IMG_W - 1));
    win_load = shift_en && row_ok && col_ok;
    win_next = '0;
    for (int unsigned i = 0; i < KSIZE; i++) begin
      for (int unsigned j = 0; j < KSIZE; j++) begin
        win_next[i*KSIZE+j] = lb_next[(KSIZE-1-i)*IMG_W + (KSIZE-1-j)];
      end
    end
  end

  // Pixel path: holding register, line buffer, raster position and window output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold       <= '0;
      hcnt       <= '0;
      lb         <= '0;
      r          <= '0;
      c          <= '0;
      win_valid  <= 1'b0;
      win_data   <= '0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (shift_en) begin
        lb         <= lb_next[LB_LEN-2:0];
        hold       <= hold >> 8;
        hcnt       <= hcnt - HW'(1);
        frame_done <= last_pix;
        if (c == CW'(IMG_W - 1)) begin
          c <= '0;
          r <= last_pix ? '0 : r + RW'(1);
        end else begin
          c <= c + CW'(1);
        end
      end
      if (pix_acc) begin
        hold <= data_in;
        hcnt <= HW'(PIX_PER_BEAT);
      end
      if (win_load) begin
        win_valid <= 1'b1;
        win_data  <= win_next;
        win_row   <= r - RW'(KSIZE - 1);
        win_col   <= c - CW'(KSIZE - 1);
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

  // Weight path: sequential word writes and the group read pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned g = 0; g < WGROUPS; g++) begin
        for (int unsigned w = 0; w < WPER_GROUP; w++) begin
          wmem[g][w] <= '0;
        end
      end
      gptr           <= '0;
      wgrp           <= '0;
      wslot          <= '0;
      weights_loaded <= 1'b0;
    end else begin
      if (weight_req) begin
        gptr <= (gptr == GW'(WGROUPS - 1)) ? '0 : gptr + GW'(1);
      end
      if (wt_acc) begin
        wmem[wgrp][wslot] <= data_in;
        if (wslot == SW'(WPER_GROUP - 1)) begin
          wslot <= '0;
          wgrp  <= (wgrp == GW'(WGROUPS - 1)) ? '0 : wgrp + GW'(1);
        end else begin
          wslot <= wslot + SW'(1);
        end
        if ((wgrp == '0) && (wslot == '0)) begin
          weights_loaded <= 1'b0;
        end
        if ((wgrp == GW'(WGROUPS - 1)) && (wslot == SW'(WPER_GROUP - 1))) begin
          weights_loaded <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    weight_out = '0;
    for (int unsigned w = 0; w < WPER_GROUP; w++) begin
      weight_out[w*DW +: DW] = wmem[gptr][w];
    end
  end

endmodule

// File: tb/tb_bnn_window_streamer.sv
// Directed bench for bnn_window_streamer: a default instance and a STRIDE=2
// instance, windows checked against a frame-image reference model.
module tb_bnn_window_streamer;

  localparam int W   = 20;
  localparam int H   = 20;
  localparam int K   = 4;
  localparam int NWP = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [15:0] data_in;
  logic        weight_req;
  logic        in_valid_a, in_valid_b;
  logic        win_ready_a, win_ready_b;

  logic        in_ready_a, in_ready_b;
  logic [95:0] weight_out_a, weight_out_b;
  logic        weights_loaded_a, weights_loaded_b;
  logic        win_valid_a, win_valid_b;
  logic [15:0] win_data_a, win_data_b;
  logic [4:0]  win_row_a, win_row_b, win_col_a, win_col_b;
  logic        frame_done_a, frame_done_b;

  always #5 clk = ~clk;

  bnn_window_streamer #(.STRIDE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .data_in(data_in), .weight_req(weight_req), .weight_out(weight_out_a),
    .weights_loaded(weights_loaded_a), .win_valid(win_valid_a), .win_ready(win_ready_a),
    .win_data(win_data_a), .win_row(win_row_a), .win_col(win_col_a), .frame_done(frame_done_a)
  );

  bnn_window_streamer #(.STRIDE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .data_in(data_in), .weight_req(weight_req), .weight_out(weight_out_b),
    .weights_loaded(weights_loaded_b), .win_valid(win_valid_b), .win_ready(win_ready_b),
    .win_data(win_data_b), .win_row(win_row_b), .win_col(win_col_b), .frame_done(frame_done_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit stuck    = 1'b0;

  logic [7:0] img [H][W];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_win(input int top, input int left);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        v[i*K+j] = (img[top+i][left+j] > 8'd127);
    return v;
  endfunction

  function automatic logic [95:0] exp_grp(input int g);
    logic [95:0] v;
    for (int w = 0; w < NWP; w++) v[w*16 +: 16] = 16'(g*NWP + w);
    return v;
  endfunction

  // Window scoreboards: expected raster position per instance
  int er_a = 0, ec_a = 0, wcnt_a = 0, fd_a = 0;
  int er_b = 0, ec_b = 0, wcnt_b = 0, fd_b = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      er_a = 0; ec_a = 0;
    end else begin
      if (win_valid_a && win_ready_a) begin
        check("a_win_row", win_row_a, er_a);
        check("a_win_col", win_col_a, ec_a);
        check("a_win_data", win_data_a, model_win(er_a, ec_a));
        wcnt_a++;
        ec_a += 1;
        if (ec_a > W - K) begin ec_a = 0; er_a += 1; if (er_a > H - K) er_a = 0; end
      end
      if (frame_done_a) fd_a++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      er_b = 0; ec_b = 0;
    end else begin
      if (win_valid_b && win_ready_b) begin
        check("b_win_row", win_row_b, er_b);
        check("b_win_col", win_col_b, ec_b);
        check("b_win_data", win_data_b, model_win(er_b, ec_b));
        wcnt_b++;
        ec_b += 2;
        if (ec_b > W - K) begin ec_b = 0; er_b += 2; if (er_b > H - K) er_b = 0; end
      end
      if (frame_done_b) fd_b++;
    end
  end

  task automatic send_beat(input bit sel, input logic [15:0] d, input logic m);
    int   t;
    logic rdy;
    if (stuck) return;
    mode = m; data_in = d;
    if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    t = 0; rdy = 1'b0;
    while (!rdy && t < 1000) begin
      @(negedge clk);
      rdy = sel ? in_ready_b : in_ready_a;
      t++;
    end
    if (!rdy) begin
      stuck = 1'b1;
      check("in_ready_timeout", rdy, 1'b1);
    end else begin
      @(posedge clk); #1;
    end
    in_valid_a = 1'b0; in_valid_b = 1'b0; mode = 1'b0;
  endtask

  task automatic stream_frame(input bit sel, input int nbeats, input int wt_at);
    int p, r, c;
    for (int b = 0; b < nbeats; b++) begin
      if (b == wt_at) send_beat(sel, 16'h5A5A, 1'b1);
      p = 2 * b; r = p / W; c = p % W;
      send_beat(sel, {img[r][c+1], img[r][c]}, 1'b0);
    end
  endtask

  task automatic pulse_req(input int n);
    for (int i = 0; i < n; i++) begin
      weight_req = 1'b1;
      @(posedge clk); #1;
      weight_req = 1'b0;
    end
  endtask

  task automatic check_reset();
    check("rst_win_valid", win_valid_a, 1'b0);
    check("rst_win_data", win_data_a, 16'h0);
    check("rst_win_row", win_row_a, 5'd0);
    check("rst_win_col", win_col_a, 5'd0);
    check("rst_frame_done", frame_done_a, 1'b0);
    check("rst_weights_loaded", weights_loaded_a, 1'b0);
    check("rst_weight_out", weight_out_a, 96'h0);
    check("rst_in_ready", in_ready_a, 1'b1);
  endtask

  initial begin
    int          base_w, base_f, t;
    logic [95:0] v;
    logic [15:0] cap_d;
    logic [4:0]  cap_r, cap_c;

    rst_n = 1'b0; mode = 1'b0; data_in = '0; weight_req = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; win_ready_a = 1'b1; win_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;

    // Weight load: 66 words, value = index
    for (int i = 0; i < 66; i++) begin
      send_beat(1'b0, 16'(i), 1'b1);
      if (i == 64) check("wl_before_last", weights_loaded_a, 1'b0);
    end
    check("wl_loaded", weights_loaded_a, 1'b1);
    check("wl_group0", weight_out_a, exp_grp(0));
    pulse_req(11);
    check("wl_wrap11", weight_out_a, exp_grp(0));
    pulse_req(1);
    check("wl_group1", weight_out_a, exp_grp(1));
    pulse_req(9);
    check("wl_group10", weight_out_a, exp_grp(10));
    pulse_req(1);
    check("wl_group_wrap", weight_out_a, exp_grp(0));
    // Simultaneous weight_req and rewrite of index 0
    weight_req = 1'b1;
    send_beat(1'b0, 16'hABCD, 1'b1);
    weight_req = 1'b0;
    check("wl_reload_clears", weights_loaded_a, 1'b0);
    check("wl_req_with_write", weight_out_a, exp_grp(1));
    pulse_req(10);
    v = exp_grp(0); v[15:0] = 16'hABCD;
    check("wl_rewritten", weight_out_a, v);

    // Full frame of 0xFF
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'hFF;
    base_w = wcnt_a; base_f = fd_a;
    stream_frame(1'b0, 200, -1);
    repeat (10) @(posedge clk); #1;
    check("ff_windows", 32'(wcnt_a - base_w), 32'd289);
    check("ff_frame_done", 32'(fd_a - base_f), 32'd1);

    // Threshold checkerboard 127 / 128
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = ((r + c) % 2 == 1) ? 8'd128 : 8'd127;
    base_w = wcnt_a; base_f = fd_a;
    stream_frame(1'b0, 200, -1);
    repeat (10) @(posedge clk); #1;
    check("cb_windows", 32'(wcnt_a - base_w), 32'd289);
    check("cb_frame_done", 32'(fd_a - base_f), 32'd1);

    // Backpressure mid-frame
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'((r * 37 + c * 11 + r * c) % 256);
    base_w = wcnt_a; base_f = fd_a;
    fork
      stream_frame(1'b0, 200, -1);
      begin
        repeat (150) @(posedge clk);
        #1 win_ready_a = 1'b0;
        t = 0;
        while (!win_valid_a && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        check("bp_valid_seen", win_valid_a, 1'b1);
        cap_d = win_data_a; cap_r = win_row_a; cap_c = win_col_a;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("bp_valid_held", win_valid_a, 1'b1);
          check("bp_data_stable", win_data_a, cap_d);
          check("bp_row_stable", win_row_a, cap_r);
          check("bp_col_stable", win_col_a, cap_c);
        end
        check("bp_in_ready_low", in_ready_a, 1'b0);
        @(posedge clk); #1 win_ready_a = 1'b1;
      end
    join
    repeat (10) @(posedge clk); #1;
    check("bp_windows", 32'(wcnt_a - base_w), 32'd289);
    check("bp_frame_done", 32'(fd_a - base_f), 32'd1);

    // STRIDE=2 with column-index image and an interleaved weight beat
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'(c * 13);
    base_w = wcnt_b; base_f = fd_b;
    stream_frame(1'b1, 200, 77);
    repeat (10) @(posedge clk); #1;
    check("s2_windows", 32'(wcnt_b - base_w), 32'd81);
    check("s2_frame_done", 32'(fd_b - base_f), 32'd1);

    // Reset after 50 beats, then a full frame
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'((r * 29 + c * 53) % 256);
    stream_frame(1'b0, 50, -1);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;
    base_w = wcnt_a; base_f = fd_a;
    stream_frame(1'b0, 200, -1);
    repeat (10) @(posedge clk); #1;
    check("rs_windows", 32'(wcnt_a - base_w), 32'd289);
    check("rs_frame_done", 32'(fd_a - base_f), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bnn_window_streamer.md
# bnn_window_streamer

Parametrised input front-end for the BNN accelerator. It accepts a packed byte stream on a valid/ready handshake and binarises each pixel against a threshold. It assembles KSIZE×KSIZE binary windows through a line buffer, with configurable image size, stride and pixels per beat, and emits them on a backpressured output. It also stores the full weight set and presents one group of weight words per `weight_req` step to the conv/FC compute array.

## Interface
- IMG_W, 20, image width in pixels; must be a multiple of PIX_PER_BEAT
- IMG_H, 20, image height in pixels
- KSIZE, 4, window edge; 2..IMG_H and ≤ IMG_W
- STRIDE, 1, window step, horizontal and vertical
- PIX_PER_BEAT, 2, 8-bit pixels per input beat; DW = 8·PIX_PER_BEAT
- THRESH, 127, a pixel binarises to 1 iff byte > THRESH (unsigned)
- WGROUPS, 11, number of weight groups
- WPER_GROUP, 6, DW-bit weight words per group
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- mode  in  1  1 = beat carries a weight word, 0 = beat carries pixels
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- data_in  in  DW  byte 0 is the first (leftmost) pixel
- weight_req  in  1  advance to next weight group
- weight_out  out  WPER_GROUP·DW  word w of current group at [w·DW +: DW]
- weights_loaded  out  1  full weight set present
- win_valid  out  1  window available
- win_ready  in  1  window consumed when win_valid & win_ready
- win_data  out  KSIZE²  bit i·KSIZE+j = pixel (top+i, left+j)
- win_row, win_col  out  $clog2(IMG_H), $clog2(IMG_W)  top-left coordinate of window
- frame_done  out  1  one-cycle pulse after last pixel of frame enters buffer

## Operation
- Weight path, on accepted beat with mode=1:
  - Write word at index wcnt, where group = wcnt / WPER_GROUP and slot = wcnt % WPER_GROUP.
  - wcnt wraps to 0 after WGROUPS·WPER_GROUP−1.
  - weights_loaded clears when index 0 is written and sets when the last index is written.
- Group pointer gptr: increments on weight_req and wraps WGROUPS−1→0. weight_out is combinational from gptr.
- Pixel path, on accepted beat with mode=0:
  - Load the beat into the holding register and set hcnt = PIX_PER_BEAT.
  - Each shift cycle, binarise the next byte (byte 0 first) and shift it into a (KSIZE−1)·IMG_W+KSIZE-bit line buffer.
  - Position counters (r, c) advance in raster order.
- Shift enable: hcnt≠0 && !(win_valid && !win_ready).
- in_ready: (hcnt==0 || (hcnt==1 && shift enable)) when mode=0; always 1 when mode=1.
  - A weight beat never disturbs the holding register or pixel position, so frames may be paused for weight loads.
- Window emission: when the pixel at (r, c) shifts in and all of the following hold, load win_data/win_row/win_col and set win_valid:
  - r ≥ KSIZE−1 and c ≥ KSIZE−1
  - (r−KSIZE+1) % STRIDE == 0 and (c−KSIZE+1) % STRIDE == 0
- win_valid clears on handshake unless a new window loads in the same cycle.
- Windows never straddle rows: column wrap is handled by the c condition.
- Frame end: when (IMG_H−1, IMG_W−1) shifts in, r and c return to 0 and frame_done pulses. The final window is emitted in the same cycle.

## Timing
- Reset (synchronous, rst_n=0 at a clk edge) clears all state to these values:
  - win_valid=0, win_data=0, win_row=0, win_col=0
  - frame_done=0, weights_loaded=0
  - weight storage 0, so weight_out=0
  - gptr=0, wcnt=0, hcnt=0, so in_ready=1
- Reset mid-frame discards the partial frame. The next accepted pixel is (0,0).
- A beat accepted at edge t shifts pixel k at edge t+1+k, stall-free. Sustained rate is 1 beat per PIX_PER_BEAT cycles.
- win_valid rises after the edge at which the qualifying pixel shifts. Minimum latency from beat acceptance is 1+k cycles for pixel k.
- While win_valid && !win_ready, win_data, win_row and win_col are held stable and no shift occurs.
- weight_req and a weight write in the same cycle: both take effect; weight_out reflects new contents next cycle.
- A weight_req pulse at gptr=WGROUPS−1 yields group 0 after the edge.

## Test plan
- Weight load: 66 mode=1 beats with value = index → weights_loaded=1 after the 66th. weight_out = {5,4,3,2,1,0}. After 11 weight_req pulses it shows {5..0} again; after 1 pulse it shows {11..6}.
- Full frame with all bytes 0xFF, defaults, win_ready=1 → exactly 289 windows of 0xFFFF in raster order (0,0)…(16,16). One frame_done after the 200th beat.
- Threshold check: bytes 127 → bit 0, bytes 128 → bit 1. Checkerboard image → each window matches the reference-model bit pattern at every position.
- Backpressure: win_ready low for 10 cycles mid-frame → win_data and win_row/win_col stable, in_ready low once the holding register is full. The window count stays 289 with no loss or duplication.
- STRIDE=2 with a column-index image → 81 windows at even coordinates. A weight beat interleaved mid-frame leaves window contents unchanged.
- rst_n low for one cycle after 50 beats → all outputs at reset values. The following full frame produces 289 windows, first at (0,0).
